// File: rtl/video_acc_pkg.sv
// ----------------------------------------------------------------------------
// video_acc_pkg
// Shared definitions for the video_acc instruction receive path:
//   - NASTI response codes
//   - register byte offsets and the word index decoded from addr[3:2]
//   - instruction opcode enumeration
//   - packed instruction entry {opcode, len} and field positions
//   - STATUS register bit positions
// ----------------------------------------------------------------------------
package video_acc_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [3:0] OFS_INST   = 4'h0;
   localparam logic [3:0] OFS_STATUS = 4'h4;
   localparam logic [3:0] OFS_FLUSH  = 4'h8;

   // Word index as seen on addr[3:2]; the byte lane bits are ignored.
   localparam logic [1:0] REG_INST   = OFS_INST[3:2];
   localparam logic [1:0] REG_STATUS = OFS_STATUS[3:2];
   localparam logic [1:0] REG_FLUSH  = OFS_FLUSH[3:2];

   localparam int STATUS_FULL_BIT  = 8;
   localparam int STATUS_EMPTY_BIT = 9;

   typedef enum logic [3:0] {
      OP_NOP             = 4'd0,
      OP_CHROMA_UPSAMPLE = 4'd2
   } opcode_e;

   localparam int OPCODE_LSB = 20;
   localparam int OPCODE_W   = 4;
   localparam int LEN_LSB    = 0;
   localparam int LEN_W      = 20;

   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [LEN_W-1:0]    len;
   } inst_t;

   function automatic inst_t word_to_inst(input logic [31:0] word);
      inst_t r;
      r.opcode = word[OPCODE_LSB +: OPCODE_W];
      r.len    = word[LEN_LSB +: LEN_W];
      return r;
   endfunction

endpackage

// File: rtl/nasti_lite_inst_receiver_if.sv
// ----------------------------------------------------------------------------
// nasti_lite_if
// NASTI-Lite (AXI4-Lite subset) bus bundle: AW, W, B, AR and R channels.
//   master modport : drives addresses/data/valids, consumes responses
//   slave  modport : the responder side (used by nasti_lite_inst_receiver)
// ----------------------------------------------------------------------------
interface nasti_lite_if #(
   parameter int ADDR_WIDTH = 12
) ();
   logic [ADDR_WIDTH-1:0] aw_addr;
   logic                  aw_valid;
   logic                  aw_ready;
   logic [31:0]           w_data;
   logic [3:0]            w_strb;
   logic                  w_valid;
   logic                  w_ready;
   logic [1:0]            b_resp;
   logic                  b_valid;
   logic                  b_ready;
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic                  ar_valid;
   logic                  ar_ready;
   logic [31:0]           r_data;
   logic [1:0]            r_resp;
   logic                  r_valid;
   logic                  r_ready;

   modport master (
      output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_valid, r_ready,
      input  aw_ready, w_ready, b_resp, b_valid, ar_ready,
             r_data, r_resp, r_valid
   );

   modport slave (
      input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_valid, r_ready,
      output aw_ready, w_ready, b_resp, b_valid, ar_ready,
             r_data, r_resp, r_valid
   );
endinterface

// File: rtl/inst_fifo.sv
// ----------------------------------------------------------------------------
// inst_fifo
// Synchronous instruction FIFO with occupancy outputs and a flush.
//   aclk, aresetn : clock, async active-low reset
//   push/push_data: write one entry (ignored while full, no full bypass)
//   pop           : drop the head entry (ignored while empty)
//   flush         : empty the FIFO; wins over a same-cycle pop
//   head          : registered head entry
//   count/full/empty : occupancy, count ranges 0..DEPTH
// ----------------------------------------------------------------------------
module inst_fifo
   import video_acc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   push,
   input  inst_t                  push_data,
   input  logic                   pop,
   input  logic                   flush,
   output inst_t                  head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   inst_t            mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/nasti_lite_inst_receiver.sv
// ----------------------------------------------------------------------------
// nasti_lite_inst_receiver
// NASTI-Lite responder terminating the instruction DMA stream. Each 32-bit
// write to INST becomes one {opcode, len} FIFO entry presented to the core
// over inst_valid/inst_ready. STATUS (read-only) and FLUSH share the port.
//   aclk, aresetn : clock, async active-low reset
//   bus           : NASTI-Lite slave port (AW/W/B/AR/R)
//   inst_valid    : FIFO head valid
//   inst_ready    : core accepts the head
//   inst_opcode   : head opcode (word bits [23:20])
//   inst_len      : head length in bytes (word bits [19:0])
//
// Write FSM
//   state   | meaning
//   WR_IDLE | collecting AW/W into holders; commits once both are full
//   WR_RESP | write committed, b_valid held until b_ready; holders stay full
// ----------------------------------------------------------------------------
module nasti_lite_inst_receiver
   import video_acc_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        aclk,
   input  logic        aresetn,
   nasti_lite_if.slave bus,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [3:0]  inst_opcode,
   output logic [19:0] inst_len
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef enum logic {
      WR_IDLE,
      WR_RESP
   } wr_state_e;

   wr_state_e             wr_state;
   logic                  aw_full;
   logic                  w_full;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [3:0]            w_strb_q;
   logic                  aw_ready_q;
   logic                  w_ready_q;
   logic                  b_valid_q;
   logic [1:0]            b_resp_q;
   logic                  ar_ready_q;
   logic                  r_valid_q;
   logic [DATA_WIDTH-1:0] r_data_q;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  b_hs;
   logic                  ar_hs;
   logic                  aw_full_n;
   logic                  w_full_n;
   logic                  r_valid_n;

   logic                  addr_ok;
   logic                  is_inst_full;
   logic                  is_flush;
   logic                  commit;
   logic                  push;
   logic                  flush;
   logic [1:0]            commit_resp;
   logic                  ar_is_status;
   logic [DATA_WIDTH-1:0] status_word;

   inst_t                 fifo_head;
   logic [CNT_W-1:0]      fifo_count;
   logic                  fifo_full;
   logic                  fifo_empty;

   assign bus.aw_ready = aw_ready_q;
   assign bus.w_ready  = w_ready_q;
   assign bus.b_valid  = b_valid_q;
   assign bus.b_resp   = b_resp_q;
   assign bus.ar_ready = ar_ready_q;
   assign bus.r_valid  = r_valid_q;
   assign bus.r_data   = r_data_q;
   assign bus.r_resp   = RESP_OKAY;

   assign aw_hs = bus.aw_valid && aw_ready_q;
   assign w_hs  = bus.w_valid  && w_ready_q;
   assign b_hs  = b_valid_q    && bus.b_ready;
   assign ar_hs = bus.ar_valid && ar_ready_q;

   // Holders only fill in IDLE and only drain on the B handshake, so the two
   // events never coincide for the same holder.
   assign aw_full_n = b_hs ? 1'b0 : (aw_hs ? 1'b1 : aw_full);
   assign w_full_n  = b_hs ? 1'b0 : (w_hs  ? 1'b1 : w_full);
   assign r_valid_n = ar_hs || (r_valid_q && !bus.r_ready);

   always_comb begin
      addr_ok      = (aw_addr_q[ADDR_WIDTH-1:4] == '0);
      is_inst_full = addr_ok && (aw_addr_q[3:2] == REG_INST) && (w_strb_q == 4'hF);
      is_flush     = addr_ok && (aw_addr_q[3:2] == REG_FLUSH);
      // A full-strobe INST write waits for room; everything else commits at once.
      commit       = (wr_state == WR_IDLE) && aw_full && w_full &&
                     !(is_inst_full && fifo_full);
      push         = commit && is_inst_full;
      flush        = commit && is_flush && w_data_q[0];
      commit_resp  = (is_inst_full || is_flush) ? RESP_OKAY : RESP_SLVERR;
   end

   always_comb begin
      ar_is_status                  = (bus.ar_addr[ADDR_WIDTH-1:4] == '0) &&
                                      (bus.ar_addr[3:2] == REG_STATUS);
      status_word                   = '0;
      status_word[7:0]              = 8'(fifo_count);
      status_word[STATUS_FULL_BIT]  = fifo_full;
      status_word[STATUS_EMPTY_BIT] = fifo_empty;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_state   <= WR_IDLE;
         aw_full    <= 1'b0;
         w_full     <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         aw_ready_q <= 1'b0;
         w_ready_q  <= 1'b0;
         b_valid_q  <= 1'b0;
         b_resp_q   <= RESP_OKAY;
      end else begin
         aw_full    <= aw_full_n;
         w_full     <= w_full_n;
         aw_ready_q <= !aw_full_n;
         w_ready_q  <= !w_full_n;
         if (aw_hs) begin
            aw_addr_q <= bus.aw_addr;
         end
         if (w_hs) begin
            w_data_q <= bus.w_data;
            w_strb_q <= bus.w_strb;
         end
         case (wr_state)
            WR_IDLE: begin
               if (commit) begin
                  wr_state  <= WR_RESP;
                  b_valid_q <= 1'b1;
                  b_resp_q  <= commit_resp;
               end
            end
            WR_RESP: begin
               if (b_hs) begin
                  wr_state  <= WR_IDLE;
                  b_valid_q <= 1'b0;
                  b_resp_q  <= RESP_OKAY;
               end
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         ar_ready_q <= 1'b0;
         r_valid_q  <= 1'b0;
         r_data_q   <= '0;
      end else begin
         ar_ready_q <= !r_valid_n;
         r_valid_q  <= r_valid_n;
         if (ar_hs) begin
            r_data_q <= ar_is_status ? status_word : '0;
         end
      end
   end

   inst_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_inst_fifo (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .push      (push),
      .push_data (word_to_inst(w_data_q)),
      .pop       (inst_valid && inst_ready),
      .flush     (flush),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign inst_valid  = !fifo_empty;
   assign inst_opcode = fifo_head.opcode;
   assign inst_len    = fifo_head.len;

   // Byte-lane address bits and the upper data byte carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{aw_addr_q[1:0], bus.ar_addr[1:0], w_data_q[DATA_WIDTH-1:24]};

endmodule

// File: tb/tb_nasti_lite_inst_receiver.sv
module tb_nasti_lite_inst_receiver;
   import video_acc_pkg::*;

   logic        aclk;
   logic        aresetn;
   logic        inst_valid;
   logic        inst_ready;
   logic [3:0]  inst_opcode;
   logic [19:0] inst_len;

   int vec_cnt     = 0;
   int miscompares = 0;

   logic [1:0]  resp;
   bit          got;
   logic [31:0] rd;

   nasti_lite_if #(.ADDR_WIDTH(12)) bus ();

   nasti_lite_inst_receiver #(
      .ADDR_WIDTH (12),
      .DATA_WIDTH (32),
      .FIFO_DEPTH (8)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .bus         (bus),
      .inst_valid  (inst_valid),
      .inst_ready  (inst_ready),
      .inst_opcode (inst_opcode),
      .inst_len    (inst_len)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_aw_w(input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly);
      bit aw_done;
      bit w_done;
      bit aw_hit;
      bit w_hit;
      aw_done     = 1'b0;
      w_done      = 1'b0;
      bus.aw_addr = addr;
      bus.w_data  = data;
      bus.w_strb  = strb;
      for (int i = 0; i < 40 && !(aw_done && w_done); i++) begin
         if (i == aw_dly) bus.aw_valid = 1'b1;
         if (i == w_dly)  bus.w_valid  = 1'b1;
         aw_hit = bus.aw_valid && bus.aw_ready;
         w_hit  = bus.w_valid && bus.w_ready;
         @(posedge aclk); #1;
         if (aw_hit) begin bus.aw_valid = 1'b0; aw_done = 1'b1; end
         if (w_hit)  begin bus.w_valid  = 1'b0; w_done  = 1'b1; end
      end
      chk("aw_w_accepted", {30'b0, aw_done, w_done}, 32'h3);
      bus.aw_valid = 1'b0;
      bus.w_valid  = 1'b0;
   endtask

   task automatic wait_b(input int max_cyc, output logic [1:0] r, output bit g);
      g           = 1'b0;
      r           = 2'bxx;
      bus.b_ready = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         if (bus.b_valid) begin
            r = bus.b_resp;
            g = 1'b1;
            @(posedge aclk); #1;
            break;
         end
         @(posedge aclk); #1;
      end
      bus.b_ready = 1'b0;
   endtask

   task automatic axi_read(input logic [11:0] addr, output logic [31:0] data);
      bit hit;
      bit ar_done;
      bit r_done;
      ar_done      = 1'b0;
      r_done       = 1'b0;
      data         = 32'hxxxx_xxxx;
      bus.ar_addr  = addr;
      bus.ar_valid = 1'b1;
      for (int i = 0; i < 20 && !ar_done; i++) begin
         hit = bus.ar_ready;
         @(posedge aclk); #1;
         if (hit) ar_done = 1'b1;
      end
      bus.ar_valid = 1'b0;
      bus.r_ready  = 1'b1;
      for (int i = 0; i < 20 && !r_done; i++) begin
         if (bus.r_valid) begin
            data   = bus.r_data;
            r_done = 1'b1;
            chk("r_resp", {30'b0, bus.r_resp}, 32'h0);
         end
         @(posedge aclk); #1;
      end
      bus.r_ready = 1'b0;
      chk("read_done", {30'b0, ar_done, r_done}, 32'h3);
   endtask

   task automatic write_expect(input string tag, input logic [11:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input logic [1:0] exp_resp);
      logic [1:0] r;
      bit         g;
      send_aw_w(addr, data, strb, 0, 0);
      wait_b(20, r, g);
      chk(tag, {29'b0, g, r}, {29'b0, 1'b1, exp_resp});
   endtask

   task automatic pop_one();
      inst_ready = 1'b1;
      @(posedge aclk); #1;
      inst_ready = 1'b0;
   endtask

   task automatic chk_head(input string tag, input logic [3:0] op, input logic [19:0] len);
      chk(tag, {7'b0, inst_valid, inst_opcode, inst_len}, {7'b0, 1'b1, op, len});
   endtask

   initial begin
      aresetn      = 1'b0;
      inst_ready   = 1'b0;
      bus.aw_addr  = '0;
      bus.aw_valid = 1'b0;
      bus.w_data   = '0;
      bus.w_strb   = '0;
      bus.w_valid  = 1'b0;
      bus.b_ready  = 1'b0;
      bus.ar_addr  = '0;
      bus.ar_valid = 1'b0;
      bus.r_ready  = 1'b0;

      // reset state
      repeat (3) @(posedge aclk);
      #1;
      chk("rst_ready_valid",
          {26'b0, bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid, inst_valid},
          32'h0);
      chk("rst_resp_data", {bus.b_resp, bus.r_resp, 28'b0}, 32'h0);
      chk("rst_r_data", bus.r_data, 32'h0);
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      chk("post_rst_ready", {29'b0, bus.aw_ready, bus.w_ready, bus.ar_ready}, 32'h7);

      // single write
      write_expect("single_b_okay", 12'h000, 32'h0020_000D, 4'hF, RESP_OKAY);
      chk_head("single_head", 4'd2, 20'd13);
      pop_one();
      chk("single_popped", {31'b0, inst_valid}, 32'h0);

      // W three cycles before AW, second AW blocked while B pending
      send_aw_w(12'h000, 32'h0010_0005, 4'hF, 3, 0);
      bus.aw_addr  = 12'h000;
      bus.aw_valid = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      chk("w_first_b_pending", {31'b0, bus.b_valid}, 32'h1);
      chk("second_aw_blocked", {31'b0, bus.aw_ready}, 32'h0);
      wait_b(10, resp, got);
      chk("w_first_b", {29'b0, got, resp}, 32'h4);
      chk("aw_ready_after_b", {31'b0, bus.aw_ready}, 32'h1);
      send_aw_w(12'h000, 32'h0030_0007, 4'hF, 0, 0);
      wait_b(10, resp, got);
      chk("second_write_b", {29'b0, got, resp}, 32'h4);
      axi_read(12'h004, rd);
      chk("status_two", rd, 32'h0000_0002);
      axi_read(12'h000, rd);
      chk("read_inst_zero", rd, 32'h0);
      chk_head("order_a", 4'd1, 20'd5);
      pop_one();
      chk_head("order_b", 4'd3, 20'd7);
      pop_one();
      chk("drained", {31'b0, inst_valid}, 32'h0);

      // fill to full, ninth write stalls
      for (int k = 0; k < 8; k++) begin
         write_expect("fill_b", 12'h000, 32'((k << 20) | (k + 16)), 4'hF, RESP_OKAY);
      end
      send_aw_w(12'h000, 32'h0080_0018, 4'hF, 0, 0);
      wait_b(8, resp, got);
      chk("full_no_b", {31'b0, got}, 32'h0);
      chk("full_aw_held", {31'b0, bus.aw_ready}, 32'h0);
      axi_read(12'h004, rd);
      chk("status_full_stall", rd, 32'h0000_0108);
      chk_head("full_head", 4'd0, 20'd16);
      pop_one();
      wait_b(5, resp, got);
      chk("ninth_b_after_pop", {29'b0, got, resp}, 32'h4);
      axi_read(12'h004, rd);
      chk("status_full", rd, 32'h0000_0108);
      chk_head("head_after_pop", 4'd1, 20'd17);

      // drain to 3, then push and pop in the same cycle
      inst_ready = 1'b1;
      repeat (5) @(posedge aclk);
      #1;
      inst_ready = 1'b0;
      chk_head("head_k6", 4'd6, 20'd22);
      send_aw_w(12'h000, 32'h0090_0099, 4'hF, 0, 0);
      inst_ready = 1'b1;
      @(posedge aclk); #1;
      inst_ready = 1'b0;
      chk("pushpop_commit", {31'b0, bus.b_valid}, 32'h1);
      wait_b(5, resp, got);
      chk("pushpop_b", {29'b0, got, resp}, 32'h4);
      axi_read(12'h004, rd);
      chk("status_pushpop", rd, 32'h0000_0003);
      chk_head("pp_order_0", 4'd7, 20'd23);
      pop_one();
      chk_head("pp_order_1", 4'd8, 20'd24);
      pop_one();
      chk_head("pp_order_2", 4'd9, 20'h99);
      pop_one();
      chk("pp_empty", {31'b0, inst_valid}, 32'h0);

      // error responses
      write_expect("err_pre_push", 12'h000, 32'h00A0_0001, 4'hF, RESP_OKAY);
      write_expect("err_strb3", 12'h000, 32'h00E0_0001, 4'h3, RESP_SLVERR);
      write_expect("err_status_wr", 12'h004, 32'h0000_0001, 4'hF, RESP_SLVERR);
      write_expect("err_addr_40", 12'h040, 32'h00E0_0002, 4'hF, RESP_SLVERR);
      write_expect("err_addr_c", 12'h00C, 32'h00E0_0003, 4'hF, RESP_SLVERR);
      axi_read(12'h004, rd);
      chk("status_after_err", rd, 32'h0000_0001);
      write_expect("low_bits_ignored", 12'h002, 32'h00B0_0002, 4'hF, RESP_OKAY);
      axi_read(12'h004, rd);
      chk("status_low_bits", rd, 32'h0000_0002);
      chk_head("err_head", 4'hA, 20'd1);

      // flush with a pop requested in the same cycle
      write_expect("fl_fill_0", 12'h000, 32'h00C0_0003, 4'hF, RESP_OKAY);
      write_expect("fl_fill_1", 12'h000, 32'h00C0_0004, 4'hF, RESP_OKAY);
      write_expect("fl_fill_2", 12'h000, 32'h00C0_0005, 4'hF, RESP_OKAY);
      write_expect("flush_zero", 12'h008, 32'h0000_0000, 4'hF, RESP_OKAY);
      axi_read(12'h004, rd);
      chk("status_five", rd, 32'h0000_0005);
      send_aw_w(12'h008, 32'h0000_0001, 4'hF, 0, 0);
      inst_ready = 1'b1;
      @(posedge aclk); #1;
      chk("flush_valid_drop", {31'b0, inst_valid}, 32'h0);
      inst_ready = 1'b0;
      wait_b(5, resp, got);
      chk("flush_b", {29'b0, got, resp}, 32'h4);
      axi_read(12'h004, rd);
      chk("status_flushed", rd, 32'h0000_0200);

      // reset while B pending
      send_aw_w(12'h000, 32'h0020_0001, 4'hF, 0, 0);
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_b_pending", {31'b0, bus.b_valid}, 32'h1);
      aresetn = 1'b0;
      #1;
      chk("rst_b_drop", {29'b0, bus.b_valid, bus.aw_ready, inst_valid}, 32'h0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      repeat (2) @(posedge aclk);
      #1;
      axi_read(12'h004, rd);
      chk("status_after_rst", rd, 32'h0000_0200);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
      $finish;
   end

endmodule

// File: doc/nasti_lite_inst_receiver.md
Name: nasti_lite_inst_receiver

Overview:
NASTI-Lite responder inside video_acc that terminates the instruction DMA stream written by the instruction data mover. It accepts 32-bit instruction writes, decodes each into opcode and length fields, and buffers them in a FIFO. Entries are presented to the accelerator core over a valid/ready handshake. A small read-only status register and a flush control are also exposed on the same port.

Parameters:
ADDR_WIDTH, 12, NASTI-Lite address width (byte address)
DATA_WIDTH, 32, data width; only 32 is supported
FIFO_DEPTH, 8, instruction FIFO entries; power of two, minimum 2

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
aw_addr  in  ADDR_WIDTH  write address
aw_valid  in  1  write address valid
aw_ready  out  1  write address ready
w_data  in  32  write data
w_strb  in  4  write strobes
w_valid  in  1  write data valid
w_ready  out  1  write data ready
b_resp  out  2  write response
b_valid  out  1  write response valid
b_ready  in  1  write response ready
ar_addr  in  ADDR_WIDTH  read address
ar_valid  in  1  read address valid
ar_ready  out  1  read address ready
r_data  out  32  read data
r_resp  out  2  read response
r_valid  out  1  read data valid
r_ready  in  1  read data ready
inst_valid  out  1  FIFO head valid
inst_ready  in  1  core accepts head
inst_opcode  out  4  head opcode, word bits [23:20]
inst_len  out  20  head length in bytes, word bits [19:0]

Behaviour:
- Reset (aresetn low, asynchronous): all ready/valid outputs 0; b_resp, r_resp, r_data 0; FIFO empty; holding registers cleared. Reset mid-transaction discards the in-flight write and any pending B/R response.
- Register map (byte offsets): 0x0 INST (write-only, pushes one entry); 0x4 STATUS (read-only: [7:0] count, [8] full, [9] empty); 0x8 FLUSH (a write with data[0]=1 empties the FIFO).
- Write path: AW and W are captured into separate one-deep holding registers. aw_ready = AW holder empty and no B pending; w_ready likewise for W. AW and W may arrive in either order or in the same cycle.
- Commit: once both holders are full, commit in the cycle the commit condition holds, then assert b_valid on the next cycle. Commit conditions:
  - INST with w_strb=4'hF: requires FIFO not full; while full, the commit stalls and neither holder is released.
  - INST with a partial strobe, or any write to STATUS or an unmapped offset: b_resp=SLVERR (2'b10), no side effect.
  - All other commits: b_resp=OKAY (2'b00).
- B handshake: b_valid is held until b_ready; holders are released on that handshake. Only one write is outstanding at a time.
- Read path: ar_ready=1 when no R is pending. r_valid is asserted the cycle after the AR handshake and held until r_ready.
  - STATUS returns a snapshot taken at AR acceptance.
  - Any other offset returns r_data=0 with OKAY.
- FIFO: push and pop in the same cycle are allowed (count unchanged). There is no full bypass: a push needs !full in that cycle, even if a pop also occurs.
- FIFO pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Output handshake: inst_valid=!empty. inst_opcode and inst_len are driven from the registered head entry. A pop occurs on inst_valid && inst_ready.
- Flush: applied at commit. A flush takes priority over a same-cycle pop. inst_valid drops on the cycle after the commit.
- Address decode uses aw_addr[3:2]; the low two bits are ignored. Bits above bit 3 must be 0, otherwise the write returns SLVERR.

Decomposition:
- Package video_acc_pkg holds:
  - NASTI response codes (OKAY, SLVERR).
  - Register offset constants.
  - Opcode enum (4-bit; 2 = CHROMA_UPSAMPLE, 0 = NOP).
  - Instruction struct packed {opcode[3:0], len[19:0]} and field-position constants.
- One sub-module, inst_fifo: synchronous FIFO with count/full/empty outputs and a flush input.

Test Plan:
- Post-reset single write: write 0x0020000D to 0x0 -> b_resp=OKAY; inst_valid=1 with inst_opcode=2, inst_len=13; inst_ready=1 -> inst_valid=0.
- W before AW: W presented 3 cycles before AW -> exactly one push and one B; a second AW is blocked (aw_ready=0) until b_ready.
- Fill to full: 9 writes with FIFO_DEPTH=8 and inst_ready=0.
  - The 9th write receives no B while full.
  - One pop -> 9th write commits with OKAY; STATUS read returns count=8, full=1.
- Same-cycle push and pop at count=3 -> count stays 3 and entry order is preserved.
- Error cases -> each returns SLVERR with no push and count unchanged:
  - write with w_strb=4'h3 to 0x0;
  - write to 0x4;
  - write to 0x40.
- Flush and reset:
  - With 5 entries queued and inst_ready=1, write 1 to 0x8 -> FIFO empty the next cycle and STATUS empty=1.
  - aresetn low while b_valid pending -> b_valid=0 immediately.
